// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared definitions for the pipelined immediate generator:
//                RV opcode constants, the output format encoding and the
//                datapath-width legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_op_imm32 = 7'b0011011;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_op32     = 7'b0111011;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;

  // Immediate format reported on out_fmt
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  // Only RV32 and RV64 datapaths are supported.
  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_format_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_format_decode
//  Description : Combinational opcode decoder and immediate extender.
//                Classifies the instruction word into an immediate format,
//                builds the sign/zero-extended XLEN-wide immediate and flags
//                opcodes that are not recognised for this XLEN.
//  Ports       : i_instr   - raw 32-bit instruction word
//                o_imm     - extended immediate (0 for NONE)
//                o_fmt     - immediate format code
//                o_illegal - opcode not recognised
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [6:0]      w_opc;
  logic [2:0]      w_funct3;
  logic            w_sign;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt5;
  logic [XLEN-1:0] w_shamt6;
  logic [XLEN-1:0] w_zimm;
  logic            w_is_shift;

  assign w_opc    = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_sign   = i_instr[31];

  // Every signed format keeps bit 31 as its sign bit, so the replication
  // count absorbs the top field bit and stays positive for XLEN=32.
  assign w_imm_i  = {{(XLEN-11){w_sign}}, i_instr[30:20]};
  assign w_imm_s  = {{(XLEN-11){w_sign}}, i_instr[30:25], i_instr[11:7]};
  assign w_imm_b  = {{(XLEN-12){w_sign}}, i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
  assign w_imm_u  = {{(XLEN-31){w_sign}}, i_instr[30:12], 12'b0};
  assign w_imm_j  = {{(XLEN-20){w_sign}}, i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
  assign w_shamt5 = {{(XLEN-5){1'b0}}, i_instr[24:20]};
  assign w_shamt6 = {{(XLEN-6){1'b0}}, i_instr[25:20]};
  assign w_zimm   = {{(XLEN-5){1'b0}}, i_instr[19:15]};

  // SLLI/SRLI/SRAI (and the W forms) share funct3 001/101; funct7 is
  // never part of the immediate.
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (w_opc)
      c_opc_load, c_opc_jalr: begin
        o_imm = w_imm_i;
        o_fmt = FMT_I;
      end
      c_opc_op_imm: begin
        if (w_is_shift) begin
          o_imm = (XLEN == 64) ? w_shamt6 : w_shamt5;
          o_fmt = FMT_SHAMT;
        end else begin
          o_imm = w_imm_i;
          o_fmt = FMT_I;
        end
      end
      c_opc_op_imm32: begin
        if (XLEN == 64) begin
          if (w_is_shift) begin
            o_imm = w_shamt5;
            o_fmt = FMT_SHAMT;
          end else begin
            o_imm = w_imm_i;
            o_fmt = FMT_I;
          end
        end else begin
          o_illegal = 1'b1;
        end
      end
      c_opc_store: begin
        o_imm = w_imm_s;
        o_fmt = FMT_S;
      end
      c_opc_branch: begin
        o_imm = w_imm_b;
        o_fmt = FMT_B;
      end
      c_opc_lui, c_opc_auipc: begin
        o_imm = w_imm_u;
        o_fmt = FMT_U;
      end
      c_opc_jal: begin
        o_imm = w_imm_j;
        o_fmt = FMT_J;
      end
      c_opc_system: begin
        // CSR*I forms carry a 5-bit unsigned immediate in the rs1 field.
        if (w_funct3[2]) begin
          o_imm = w_zimm;
          o_fmt = FMT_ZIMM;
        end
      end
      c_opc_op, c_opc_misc_mem: begin
        // Legal, no immediate.
      end
      c_opc_op32: begin
        o_illegal = (XLEN != 64);
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pipe_stage
//  Description : Two-stage pipelined immediate generator with valid/ready
//                handshakes on both sides. S1 decodes and extends the
//                immediate, S2 adds the PC and drives the registered outputs.
//                Also keeps a saturating count of illegal results delivered.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                flush               - synchronous kill of both stages
//                in_valid/in_ready   - input handshake
//                in_instr, in_pc     - instruction word and its address
//                out_valid/out_ready - output handshake
//                out_imm, out_target - immediate and pc + immediate
//                out_fmt, out_illegal- format code and illegal-opcode flag
//                illegal_count       - saturating illegal-result counter
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_pipe_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_pipe_stage: XLEN must be 32 or 64");
  end

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Decoder outputs
  logic [XLEN-1:0]  w_dec_imm;
  imm_fmt_e         w_dec_fmt;
  logic             w_dec_illegal;

  // Handshake
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_out_hs;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [XLEN-1:0]  r_s1_imm;
  logic [XLEN-1:0]  r_s1_pc;
  imm_fmt_e         r_s1_fmt;
  logic             r_s1_illegal;

  // Stage 2 (output) registers
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_imm;
  logic [XLEN-1:0]  r_s2_target;
  logic [2:0]       r_s2_fmt;
  logic             r_s2_illegal;

  logic [CNT_W-1:0] r_cnt;

  imm_format_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .i_instr   (in_instr),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_illegal)
  );

  // Each stage moves when its successor has room; in_ready is the only
  // combinational path (from out_ready) through the stage.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_s2_valid && out_ready;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_imm     <= '0;
      r_s1_pc      <= '0;
      r_s1_fmt     <= FMT_NONE;
      r_s1_illegal <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_imm     <= '0;
      r_s2_target  <= '0;
      r_s2_fmt     <= '0;
      r_s2_illegal <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_imm     <= w_dec_imm;
          r_s1_pc      <= in_pc;
          r_s1_fmt     <= w_dec_fmt;
          r_s1_illegal <= w_dec_illegal;
        end
      end

      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_imm     <= r_s1_imm;
          r_s2_target  <= r_s1_pc + r_s1_imm;
          r_s2_fmt     <= r_s1_fmt;
          r_s2_illegal <= r_s1_illegal;
        end
      end

      // Counts delivered results, so an output handshake coinciding with
      // a flush still counts.
      if (w_out_hs && r_s2_illegal && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end

      // Kill wins over any advance on the same edge.
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_imm       = r_s2_imm;
  assign out_target    = r_s2_target;
  assign out_fmt       = r_s2_fmt;
  assign out_illegal   = r_s2_illegal;
  assign illegal_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_pipe_stage
//  Description : Directed bench for imm_pipe_stage. Drives an RV32 instance
//                (CNT_W=2) and an RV64 instance (CNT_W=16) from the same
//                stimulus and compares both against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_pipe_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_target(tgt32),
    .out_fmt(fmt32), .out_illegal(ill32), .illegal_count(cnt32)
  );

  imm_pipe_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_target(tgt64),
    .out_fmt(fmt64), .out_illegal(ill64), .illegal_count(cnt64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ov32"}, ov32, 0);
    chk({tag, " ov64"}, ov64, 0);
    chk({tag, " imm32"}, imm32, 0);
    chk({tag, " imm64"}, imm64, 0);
    chk({tag, " tgt32"}, tgt32, 0);
    chk({tag, " tgt64"}, tgt64, 0);
    chk({tag, " fmt32"}, fmt32, 0);
    chk({tag, " ill64"}, ill64, 0);
    chk({tag, " cnt32"}, cnt32, 0);
    chk({tag, " cnt64"}, cnt64, 0);
    chk({tag, " rdy32"}, rdy32, 1);
    chk({tag, " rdy64"}, rdy64, 1);
  endtask

  // Single instruction through an otherwise idle pipe: accepted on the
  // first edge, visible after the second, consumed on the third.
  task automatic send_one(input logic [31:0] instr, input logic [63:0] pc);
    in_instr  = instr;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int exp_c32;
    int exp_c64;
    logic [1:0] sat_seq [5];
    logic [31:0] id;

    vecs[0]  = '{32'hFFF00093, 64'h100,      32'hFFFFFFFF, 32'h000000FF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFF,        3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 64'h100,      32'hFFFFFFFC, 32'h000000FC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'hFC,        3'd3, 1'b0};
    vecs[2]  = '{32'h0010006F, 64'hFFFFF800, 32'h00000800, 32'h00000000, 3'd5, 1'b0, 64'h800,              64'h100000000, 3'd5, 1'b0};
    vecs[3]  = '{32'h41F0D093, 64'h0,        32'h1F,       32'h1F,       3'd6, 1'b0, 64'h1F,               64'h1F,        3'd6, 1'b0};
    vecs[4]  = '{32'h4230D093, 64'h0,        32'h3,        32'h3,        3'd6, 1'b0, 64'h23,               64'h23,        3'd6, 1'b0};
    vecs[5]  = '{32'h123452B7, 64'h10,       32'h12345000, 32'h12345010, 3'd4, 1'b0, 64'h12345000,         64'h12345010,  3'd4, 1'b0};
    vecs[6]  = '{32'h800002B7, 64'h0,        32'h80000000, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[7]  = '{32'h0050009B, 64'h20,       32'h0,        32'h20,       3'd0, 1'b1, 64'h5,                64'h25,        3'd1, 1'b0};
    vecs[8]  = '{32'h03F0109B, 64'h0,        32'h0,        32'h0,        3'd0, 1'b1, 64'h1F,               64'h1F,        3'd6, 1'b0};
    vecs[9]  = '{32'hFE112E23, 64'h200,      32'hFFFFFFFC, 32'h1FC,      3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h1FC,       3'd2, 1'b0};
    vecs[10] = '{32'h300FD073, 64'h0,        32'h1F,       32'h1F,       3'd7, 1'b0, 64'h1F,               64'h1F,        3'd7, 1'b0};
    vecs[11] = '{32'h00000073, 64'h8,        32'h0,        32'h8,        3'd0, 1'b0, 64'h0,                64'h8,         3'd0, 1'b0};
    vecs[12] = '{32'h002081B3, 64'h4,        32'h0,        32'h4,        3'd0, 1'b0, 64'h0,                64'h4,         3'd0, 1'b0};
    vecs[13] = '{32'h002081BB, 64'h4,        32'h0,        32'h4,        3'd0, 1'b1, 64'h0,                64'h4,         3'd0, 1'b0};
    vecs[14] = '{32'h80000067, 64'h1000,     32'hFFFFF800, 32'h800,      3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 64'h800,       3'd1, 1'b0};
    vecs[15] = '{32'hFFF03093, 64'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[16] = '{32'h0FF0000F, 64'h0,        32'h0,        32'h0,        3'd0, 1'b0, 64'h0,                64'h0,         3'd0, 1'b0};
    vecs[17] = '{32'hFFFFF017, 64'h3000,     32'hFFFFF000, 32'h2000,     3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 64'h2000,      3'd4, 1'b0};
    vecs[18] = '{32'h0000007F, 64'h40,       32'h0,        32'h40,       3'd0, 1'b1, 64'h0,                64'h40,        3'd0, 1'b1};
    vecs[19] = '{32'h00402083, 64'h10,       32'h4,        32'h14,       3'd1, 1'b0, 64'h4,                64'h14,        3'd1, 1'b0};

    sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3; sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

    in_instr = '0;
    in_pc    = '0;
    do_reset();
    chk_zero("reset");

    // ---------------- table-driven single-instruction vectors -----------
    exp_c32 = 0;
    exp_c64 = 0;
    for (int i = 0; i < NV; i++) begin
      send_one(vecs[i].instr, vecs[i].pc);
      chk($sformatf("v%0d ov32", i),  ov32,  1);
      chk($sformatf("v%0d ov64", i),  ov64,  1);
      chk($sformatf("v%0d imm32", i), imm32, vecs[i].imm32);
      chk($sformatf("v%0d tgt32", i), tgt32, vecs[i].tgt32);
      chk($sformatf("v%0d fmt32", i), fmt32, vecs[i].fmt32);
      chk($sformatf("v%0d ill32", i), ill32, vecs[i].ill32);
      chk($sformatf("v%0d imm64", i), imm64, vecs[i].imm64);
      chk($sformatf("v%0d tgt64", i), tgt64, vecs[i].tgt64);
      chk($sformatf("v%0d fmt64", i), fmt64, vecs[i].fmt64);
      chk($sformatf("v%0d ill64", i), ill64, vecs[i].ill64);
      step();
      if (vecs[i].ill32 && exp_c32 < 3) exp_c32++;
      if (vecs[i].ill64) exp_c64++;
      chk($sformatf("v%0d drained32", i), ov32, 0);
      chk($sformatf("v%0d cnt32", i), cnt32, exp_c32);
      chk($sformatf("v%0d cnt64", i), cnt64, exp_c64);
    end

    // ---------------- illegal opcode x5, counter saturation ------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_one(32'h0000007F, 64'h0);
      chk($sformatf("illrep%0d ill32", k), ill32, 1);
      chk($sformatf("illrep%0d imm32", k), imm32, 0);
      chk($sformatf("illrep%0d fmt32", k), fmt32, 0);
      step();
      chk($sformatf("illrep%0d cnt32", k), cnt32, sat_seq[k]);
      chk($sformatf("illrep%0d cnt64", k), cnt64, k + 1);
    end

    // ---------------- flush with both stages full -----------------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0000007F; in_pc = 64'h40;
    step();
    chk("fill1 rdy32", rdy32, 1);
    in_instr  = 32'h0000007F; in_pc = 64'h44;
    step();
    chk("full rdy32", rdy32, 0);
    chk("full rdy64", rdy64, 0);
    chk("full ov32", ov32, 1);
    in_instr = 32'hFFF00093; in_pc = 64'h300;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush ov32", ov32, 0);
    chk("flush ov64", ov64, 0);
    chk("flush cnt32", cnt32, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush drop%0d ov32", k), ov32, 0);
      chk($sformatf("flush drop%0d ov64", k), ov64, 0);
    end
    chk("flush cnt64", cnt64, 0);

    // Output handshake coinciding with a flush still counts.
    send_one(32'h0000007F, 64'h0);
    chk("flushhs ov32", ov32, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushhs cnt32", cnt32, 1);
    chk("flushhs cnt64", cnt64, 1);
    chk("flushhs ov32", ov32, 0);

    // ---------------- back-to-back stream with backpressure -------------
    begin : stream
      int sent, rcvd;
      bit s1v, s2v, exp_rdy, in_hs, out_hs, s2adv, s1adv;
      sent = 0; rcvd = 0; s1v = 0; s2v = 0;
      for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
        out_ready = !(cyc >= 3 && cyc <= 5);
        in_valid  = (sent < 8);
        id        = sent;
        in_instr  = {id[11:0], 20'h00093};
        in_pc     = 64'h1000 + 64'(sent * 4);
        #1;
        exp_rdy = !s1v || !s2v || out_ready;
        chk($sformatf("stream c%0d rdy32", cyc), rdy32, exp_rdy);
        chk($sformatf("stream c%0d rdy64", cyc), rdy64, exp_rdy);
        chk($sformatf("stream c%0d ov32", cyc), ov32, s2v);
        in_hs  = in_valid && exp_rdy;
        out_hs = s2v && out_ready;
        if (out_hs) begin
          chk($sformatf("stream r%0d imm32", rcvd), imm32, rcvd);
          chk($sformatf("stream r%0d tgt32", rcvd), tgt32, 32'h1000 + rcvd * 5);
          chk($sformatf("stream r%0d imm64", rcvd), imm64, rcvd);
          rcvd++;
        end
        if (in_hs) sent++;
        s2adv = !s2v || out_ready;
        s1adv = !s1v || s2adv;
        if (s2adv) s2v = s1v;
        if (s1adv) s1v = in_valid;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("stream received", rcvd, 8);
      step();
      step();
      chk("stream nodup ov32", ov32, 0);
      chk("stream nodup ov64", ov64, 0);
    end

    // ---------------- reset mid-stream ---------------------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093; in_pc = 64'h100;
    step();
    step();
    chk("pre-reset ov32", ov32, 1);
    chk("pre-reset cnt32", cnt32, 1);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk_zero("midreset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
